wallace_dot_accumulator: RTL and testbench

Downstream consumer of the 8x8 Wallace multiplier's 16-bit product P. Accepts one product per cycle over a valid/ready handshake and sums VEC_LEN products into one unsigned dot-product result. Presents each result over a second valid/ready handshake. Sits between the multiplier array and the result/writeback logic of the MAC datapath.

---
 rtl/wallace_dot_accumulator.sv | 72 +++++++
 tb/tb_wallace_dot_accumulator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wallace_dot_accumulator.sv
// wallace_dot_accumulator: sums VEC_LEN unsigned products per vector and presents each result over valid/ready.
// Define WALLACE_ACC_SATURATE_EN to saturate at 2^ACC_W-1 instead of wrapping.
module wallace_dot_accumulator #(
    parameter int PROD_W  = 16,
    parameter int ACC_W   = 19,
    parameter int VEC_LEN = 8,
    localparam int CW     = $clog2(VEC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [PROD_W-1:0] p_in,
    input  logic              p_valid,
    output logic              p_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [CW-1:0]     count
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t state;
    logic [ACC_W-1:0] acc;
    logic ovf_int;
    logic [ACC_W:0] sum;
    logic [ACC_W-1:0] nxt;
    logic accept, last;
    assign p_ready = (state == ACCUM) && !clear;
    assign accept  = p_valid && p_ready;
    assign last    = count == CW'(VEC_LEN - 1);
    assign sum     = {1'b0, acc} + (ACC_W + 1)'(p_in);
`ifdef WALLACE_ACC_SATURATE_EN
    assign nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign nxt = sum[ACC_W-1:0];
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ovf_int   <= 1'b0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ovf_int   <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept && last) begin
                acc_out   <= nxt;
                overflow  <= ovf_int | sum[ACC_W];
                out_valid <= 1'b1;
                acc       <= '0;
                count     <= '0;
                ovf_int   <= 1'b0;
                state     <= HOLD;
            end else if (accept) begin
                acc     <= nxt;
                count   <= count + CW'(1);
                ovf_int <= ovf_int | sum[ACC_W];
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
        end
    end
endmodule

// File: tb/tb_wallace_dot_accumulator.sv
// tb_wallace_dot_accumulator: directed vectors against hand-computed dot-product results.
module tb_wallace_dot_accumulator;
    logic clk = 0, rst = 1;
    logic clear = 0, p_valid = 0, out_ready = 1;
    logic [15:0] p_in = '0;
    logic p_ready, out_valid, overflow;
    logic [18:0] acc_out;
    logic [3:0] count;
    logic clear4 = 0, p_valid4 = 0, out_ready4 = 1;
    logic [15:0] p_in4 = '0;
    logic p_ready4, out_valid4, overflow4;
    logic [16:0] acc_out4;
    logic [2:0] count4;
    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    wallace_dot_accumulator u_dut (
        .clk(clk), .rst(rst), .clear(clear), .p_in(p_in), .p_valid(p_valid),
        .p_ready(p_ready), .acc_out(acc_out), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .count(count)
    );

    wallace_dot_accumulator #(.ACC_W(17), .VEC_LEN(4)) u_small (
        .clk(clk), .rst(rst), .clear(clear4), .p_in(p_in4), .p_valid(p_valid4),
        .p_ready(p_ready4), .acc_out(acc_out4), .out_valid(out_valid4),
        .out_ready(out_ready4), .overflow(overflow4), .count(count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            p_valid = 1; p_in = v;
            step();
        end
        p_valid = 0; p_in = 'x;
    endtask

    initial begin
        #12;
        check("rst p_ready", p_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst acc_out", acc_out, 0);
        check("rst count", count, 0);
        check("rst overflow", overflow, 0);
        rst = 0;
        step();
        // back-to-back max products
        feed(16'd65025, 8);
        check("t1 out_valid", out_valid, 1);
        check("t1 acc_out", acc_out, 520200);
        check("t1 overflow", overflow, 0);
        check("t1 bubble p_ready", p_ready, 0);
        check("t1 count", count, 0);
        step();
        check("t1 consumed", out_valid, 0);
        check("t1 p_ready back", p_ready, 1);
        // accepts every other cycle, result held by out_ready=0
        out_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            check("t2 count pre", count, i - 1);
            p_valid = 1; p_in = 16'(i);
            step();
            p_valid = 0; p_in = 'x;
            if (i < 8) check("t2 count idle", count, i);
            step();
            if (i < 8) check("t2 count held", count, i);
        end
        check("t2 count done", count, 0);
        for (int k = 0; k < 5; k++) begin
            check("t3 out_valid", out_valid, 1);
            check("t3 acc_out", acc_out, 36);
            check("t3 overflow", overflow, 0);
            check("t3 p_ready", p_ready, 0);
            step();
        end
        out_ready = 1;
        step();
        check("t3 consumed", out_valid, 0);
        // narrow accumulator overflows
        for (int i = 0; i < 4; i++) begin
            p_valid4 = 1; p_in4 = 16'd65025;
            step();
        end
        p_valid4 = 0;
        check("t4 out_valid", out_valid4, 1);
`ifdef WALLACE_ACC_SATURATE_EN
        check("t4 acc_out", acc_out4, 131071);
`else
        check("t4 acc_out", acc_out4, 129028);
`endif
        check("t4 overflow", overflow4, 1);
        step();
        check("t4 consumed", out_valid4, 0);
        // clear drops the concurrent product and the partial sum
        feed(16'd5, 3);
        check("t5 count", count, 3);
        p_valid = 1; p_in = 16'd100; clear = 1;
        #1;
        check("t5 p_ready", p_ready, 0);
        step();
        clear = 0; p_valid = 0;
        check("t5 count cleared", count, 0);
        check("t5 acc_out kept", acc_out, 36);
        check("t5 out_valid", out_valid, 0);
        feed(16'd1, 8);
        check("t5 out_valid", out_valid, 1);
        check("t5 acc_out", acc_out, 8);
        step();
        // async reset mid-vector, then during HOLD
        feed(16'd7, 3);
        #2 rst = 1;
        #1;
        check("t6 count", count, 0);
        check("t6 p_ready", p_ready, 1);
        check("t6 acc_out", acc_out, 0);
        rst = 0;
        step();
        out_ready = 0;
        feed(16'd9, 8);
        check("t6 hold valid", out_valid, 1);
        #2 rst = 1;
        #1;
        check("t6 hold out_valid", out_valid, 0);
        check("t6 hold acc_out", acc_out, 0);
        check("t6 hold p_ready", p_ready, 1);
        rst = 0; out_ready = 1;
        step();
        feed(16'd1000, 8);
        check("t6 out_valid", out_valid, 1);
        check("t6 acc_out", acc_out, 8000);
        check("t6 overflow", overflow, 0);
        step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
